affine_xform_engine: RTL and testbench

Parametrised successor to the fixed 2x3 point transform unit. Applies a full 2x3 affine matrix to a burst of up to MAX_PTS points. The datapath is pipelined with valid/ready handshakes on input and output, and the divide is a programmable arithmetic right shift. The block sits between the vertex buffer and the rasteriser front end; the command decoder loads coefficients and starts bursts.

---
 rtl/affine_xform_if.sv | 36 +++
 rtl/affine_xform_engine.sv | 186 ++++++++++++++++++
 tb/tb_affine_xform_engine.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/affine_xform_if.sv
// Point-input / result-output handshake bundle for affine_xform_engine.
// sat_flag is present only when AFFINE_SAT_EN is defined.
interface affine_xform_if #(
  parameter int DATA_W = 16
);
  logic                     pt_valid;
  logic                     pt_ready;
  logic signed [DATA_W-1:0] pt_x;
  logic signed [DATA_W-1:0] pt_y;
  logic                     res_valid;
  logic                     res_ready;
  logic signed [DATA_W-1:0] res_x;
  logic signed [DATA_W-1:0] res_y;
  logic                     res_last;
`ifdef AFFINE_SAT_EN
  logic                     sat_flag;
`endif

  // Upstream/downstream environment side.
  modport master (
`ifdef AFFINE_SAT_EN
    input  sat_flag,
`endif
    output pt_valid, pt_x, pt_y, res_ready,
    input  pt_ready, res_valid, res_x, res_y, res_last
  );

  // Engine side.
  modport slave (
`ifdef AFFINE_SAT_EN
    output sat_flag,
`endif
    input  pt_valid, pt_x, pt_y, res_ready,
    output pt_ready, res_valid, res_x, res_y, res_last
  );
endinterface

// File: rtl/affine_xform_engine.sv
// Burst 2x3 affine transform: two-stage pipeline, valid/ready on both sides.
// Define AFFINE_SAT_EN to saturate (and flag) instead of wrapping on reduction.
module affine_xform_engine #(
  parameter  int DATA_W  = 16,
  parameter  int MAX_PTS = 8,
  parameter  int SHIFT_W = 5,
  localparam int CNT_W   = $clog2(MAX_PTS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [6*DATA_W-1:0]   cfg_coeff,
  input  logic [SHIFT_W-1:0]    cfg_shift,
  input  logic                  start,
  input  logic [CNT_W-1:0]      npts,
  output logic                  busy,
  output logic                  done,
  affine_xform_if.slave         io
);

  localparam int PW = 2 * DATA_W;
  // Two guard bits over the product width so sum + offset never overflows.
  localparam int SW = 2 * DATA_W + 2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                   state, state_next;
  logic [CNT_W-1:0]         target, target_next;
  logic [CNT_W-1:0]         accepted, accepted_next;
  logic                     done_next;
  logic [CNT_W-1:0]         npts_clamped;

  // coeff[0..5] = c11, c12, c13, c21, c22, c23
  logic signed [DATA_W-1:0] coeff [6];
  logic [SHIFT_W-1:0]       shift;

  logic                     adv, in_fire, out_fire;
  logic                     s1_valid, s1_last;
  logic signed [PW-1:0]     p11, p12, p21, p22;
  logic signed [DATA_W-1:0] red_x, red_y;
  logic                     clip_x, clip_y;

  assign adv         = !(io.res_valid && !io.res_ready);
  assign io.pt_ready = (state == RUN) && (accepted < target) && adv;
  assign in_fire     = io.pt_valid && io.pt_ready;
  assign out_fire    = io.res_valid && io.res_ready;
  assign busy        = (state != IDLE);

  assign npts_clamped = (npts > CNT_W'(MAX_PTS)) ? CNT_W'(MAX_PTS) : npts;

  // NOTE: the coefficient file is reset like any other register because the
  // identity matrix is the architecturally visible state after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 6; i++) coeff[i] <= DATA_W'((i == 0 || i == 4) ? 1 : 0);
      shift <= '0;
    end else if (cfg_we && state == IDLE) begin
      for (int i = 0; i < 6; i++) coeff[i] <= cfg_coeff[i*DATA_W +: DATA_W];
      shift <= cfg_shift;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_next    = state;
    target_next   = target;
    accepted_next = accepted;
    done_next     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (npts_clamped == '0) begin
            done_next = 1'b1;
          end else begin
            target_next   = npts_clamped;
            accepted_next = '0;
            state_next    = RUN;
          end
        end
      end
      RUN: begin
        if (in_fire) begin
          accepted_next = accepted + CNT_W'(1);
          if (accepted + CNT_W'(1) == target) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (out_fire && io.res_last) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      target   <= '0;
      accepted <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      target   <= target_next;
      accepted <= accepted_next;
      done     <= done_next;
    end
  end

  // Stage 1: four full-width products; the last-point tag rides along.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      p11 <= '0;
      p12 <= '0;
      p21 <= '0;
      p22 <= '0;
    end else if (adv) begin
      s1_valid <= in_fire;
      s1_last  <= in_fire && (accepted == target - CNT_W'(1));
      if (in_fire) begin
        p11 <= PW'(coeff[0]) * PW'(io.pt_x);
        p12 <= PW'(coeff[1]) * PW'(io.pt_y);
        p21 <= PW'(coeff[3]) * PW'(io.pt_x);
        p22 <= PW'(coeff[4]) * PW'(io.pt_y);
      end
    end
  end

`ifdef AFFINE_SAT_EN
  logic signed [SW-1:0] off_x, off_y;

  assign off_x = ((SW'(p11) + SW'(p12)) >>> shift) + SW'(coeff[2]);
  assign off_y = ((SW'(p21) + SW'(p22)) >>> shift) + SW'(coeff[5]);

  // Clipped when the bits above the result's sign bit are not a pure sign extension.
  always_comb begin
    clip_x = !((&off_x[SW-1:DATA_W-1]) || !(|off_x[SW-1:DATA_W-1]));
    clip_y = !((&off_y[SW-1:DATA_W-1]) || !(|off_y[SW-1:DATA_W-1]));
    red_x  = off_x[DATA_W-1:0];
    red_y  = off_y[DATA_W-1:0];
    if (clip_x) red_x = off_x[SW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    if (clip_y) red_y = off_y[SW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  end
`else
  assign red_x  = DATA_W'(((SW'(p11) + SW'(p12)) >>> shift) + SW'(coeff[2]));
  assign red_y  = DATA_W'(((SW'(p21) + SW'(p22)) >>> shift) + SW'(coeff[5]));
  assign clip_x = 1'b0;
  assign clip_y = 1'b0;
`endif

  // Stage 2: result registers hold while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io.res_valid <= 1'b0;
      io.res_last  <= 1'b0;
      io.res_x     <= '0;
      io.res_y     <= '0;
`ifdef AFFINE_SAT_EN
      io.sat_flag  <= 1'b0;
`endif
    end else if (adv) begin
      io.res_valid <= s1_valid;
      io.res_last  <= s1_valid && s1_last;
      if (s1_valid) begin
        io.res_x <= red_x;
        io.res_y <= red_y;
`ifdef AFFINE_SAT_EN
        io.sat_flag <= clip_x || clip_y;
`endif
      end
    end
  end

`ifndef AFFINE_SAT_EN
  // Clip detection is compiled out in the wrapping build.
  logic unused_clip;
  assign unused_clip = clip_x ^ clip_y;
`endif

endmodule

// File: tb/tb_affine_xform_engine.sv
// Directed bench for affine_xform_engine: single-point vector table plus
// streaming, backpressure, control-ignore and mid-burst reset sequences.
module tb_affine_xform_engine;

  localparam int DATA_W  = 16;
  localparam int MAX_PTS = 8;
  localparam int SHIFT_W = 5;
  localparam int CNT_W   = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                cfg_we;
  logic [6*DATA_W-1:0] cfg_coeff;
  logic [SHIFT_W-1:0]  cfg_shift;
  logic                start;
  logic [CNT_W-1:0]    npts;
  logic                busy;
  logic                done;

  int n_checks = 0;
  int n_fail   = 0;

  affine_xform_if #(.DATA_W(DATA_W)) io ();

  affine_xform_engine #(
    .DATA_W (DATA_W),
    .MAX_PTS(MAX_PTS),
    .SHIFT_W(SHIFT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_we   (cfg_we),
    .cfg_coeff(cfg_coeff),
    .cfg_shift(cfg_shift),
    .start    (start),
    .npts     (npts),
    .busy     (busy),
    .done     (done),
    .io       (io)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    c11, c12, c13, c21, c22, c23;
    int    sh;
    int    x, y;
    int    ex, ey;
    bit    esat;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [6*DATA_W-1:0] pack_c(input int c11, input int c12, input int c13,
                                                 input int c21, input int c22, input int c23);
    return {16'(c23), 16'(c22), 16'(c21), 16'(c13), 16'(c12), 16'(c11)};
  endfunction

  // One-point burst: optional coefficient load with start, latency, result and done checks.
  task automatic run_vec(input vec_t v, input bit load);
    int lat;
    @(negedge clk);
    cfg_we    = load;
    cfg_coeff = pack_c(v.c11, v.c12, v.c13, v.c21, v.c22, v.c23);
    cfg_shift = SHIFT_W'(v.sh);
    start     = 1'b1;
    npts      = 4'd1;
    io.res_ready = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
    start  = 1'b0;
    check({v.name, " busy"}, busy, 1);
    check({v.name, " pt_ready"}, io.pt_ready, 1);
    io.pt_valid = 1'b1;
    io.pt_x     = 16'(v.x);
    io.pt_y     = 16'(v.y);
    lat = 0;
    do begin
      @(negedge clk);
      io.pt_valid = 1'b0;
      lat++;
    end while (!io.res_valid && lat < 10);
    check({v.name, " latency"}, lat, 2);
    check({v.name, " res_x"}, io.res_x, v.ex);
    check({v.name, " res_y"}, io.res_y, v.ey);
    check({v.name, " res_last"}, io.res_last, 1);
`ifdef AFFINE_SAT_EN
    check({v.name, " sat_flag"}, io.sat_flag, int'(v.esat));
`endif
    @(negedge clk);
    check({v.name, " done"}, done, 1);
    check({v.name, " busy after"}, busy, 0);
    check({v.name, " res_valid after"}, io.res_valid, 0);
    @(negedge clk);
    check({v.name, " done drop"}, done, 0);
  endtask

  // Streams points (k,k), k=1..n, into a running identity burst; optional stall
  // of stall_len cycles right after the first result is taken.
  task automatic stream(input int n, input int stall_len, input string tag);
    bit in_hs, out_hs, held, stall_armed;
    int sent, got, stall_rem;
    logic signed [DATA_W-1:0] hx, hy;
    logic hl;
    sent = 0; got = 0; stall_rem = 0; held = 1'b0; hl = 1'b0; hx = '0; hy = '0;
    stall_armed = (stall_len > 0);
    io.res_ready = 1'b1;
    io.pt_valid  = 1'b1;
    io.pt_x      = 16'sd1;
    io.pt_y      = 16'sd1;
    #1;
    in_hs  = io.pt_valid && io.pt_ready;
    out_hs = 1'b0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      if (in_hs) begin
        sent++;
        if (sent < n) begin
          io.pt_x = 16'(sent + 1);
          io.pt_y = 16'(sent + 1);
        end else begin
          io.pt_valid = 1'b0;
        end
      end
      if (out_hs) got++;
      if (got == n) break;
      if (stall_rem > 0) begin
        io.res_ready = 1'b0;
        stall_rem--;
      end else begin
        io.res_ready = 1'b1;
      end
      #1;
      if (held && io.res_valid) begin
        check({tag, " hold x"}, io.res_x, hx);
        check({tag, " hold y"}, io.res_y, hy);
        check({tag, " hold last"}, io.res_last, hl);
      end
      if (io.res_valid && !io.res_ready) check({tag, " pt_ready stall"}, io.pt_ready, 0);
      in_hs  = io.pt_valid && io.pt_ready;
      out_hs = io.res_valid && io.res_ready;
      if (out_hs) begin
        check({tag, " order x"}, io.res_x, got + 1);
        check({tag, " order y"}, io.res_y, got + 1);
        check({tag, " last"}, io.res_last, int'(got == n - 1));
        if (stall_armed) begin
          stall_rem   = stall_len;
          stall_armed = 1'b0;
        end
      end
      held = io.res_valid && !io.res_ready;
      hx = io.res_x;
      hy = io.res_y;
      hl = io.res_last;
    end
    check({tag, " count"}, got, n);
    check({tag, " inputs"}, sent, n);
    check({tag, " done"}, done, 1);
    check({tag, " res_valid end"}, io.res_valid, 0);
    @(negedge clk);
    check({tag, " done drop"}, done, 0);
    check({tag, " busy end"}, busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t idv;
    int   done_seen;

    vecs[0] = '{"translate", 1, 0, 5, 0, 1, -3, 0, 10, 20, 15, 17, 1'b0};
    vecs[1] = '{"scale_a", 3, 0, 0, 0, 3, 0, 1, 7, -4, 10, -6, 1'b0};
    vecs[2] = '{"scale_b", 3, 0, 0, 0, 3, 0, 1, 1, 1, 1, 1, 1'b0};
    vecs[3] = '{"scale_floor", 3, 0, 0, 0, 3, 0, 1, -1, -3, -2, -5, 1'b0};
    vecs[4] = '{"rotate", 0, -16384, 0, 16384, 0, 0, 14, 100, 50, -50, 100, 1'b0};
    vecs[6] = '{"general", 2, 3, -7, -1, 4, 100, 2, 5, -6, -9, 92, 1'b0};
`ifdef AFFINE_SAT_EN
    vecs[5] = '{"overflow", 32767, 0, 0, 0, 32767, 0, 0, 2, 2, 32767, 32767, 1'b1};
    vecs[7] = '{"underflow", -32768, 0, 0, 0, -32768, 0, 0, 2, -2, -32768, 32767, 1'b1};
`else
    vecs[5] = '{"overflow", 32767, 0, 0, 0, 32767, 0, 0, 2, 2, -2, -2, 1'b0};
    vecs[7] = '{"underflow", -32768, 0, 0, 0, -32768, 0, 0, 2, -2, 0, 0, 1'b0};
`endif
    idv = '{"identity", 1, 0, 0, 0, 1, 0, 0, 123, -45, 123, -45, 1'b0};

    rst = 1'b1; cfg_we = 1'b0; start = 1'b0; npts = '0;
    cfg_coeff = '0; cfg_shift = '0;
    io.pt_valid = 1'b0; io.pt_x = '0; io.pt_y = '0; io.res_ready = 1'b1;
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset pt_ready", io.pt_ready, 0);
    check("reset res_valid", io.res_valid, 0);
    check("reset res_x", io.res_x, 0);
    check("reset res_y", io.res_y, 0);
    check("reset res_last", io.res_last, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset coefficients must be the identity with zero shift.
    run_vec(idv, 1'b0);
    for (int i = 0; i < 8; i++) run_vec(vecs[i], 1'b1);

    // Empty burst: done next cycle, never busy.
    @(negedge clk);
    start = 1'b1; npts = 4'd0;
    @(negedge clk);
    start = 1'b0;
    check("npts0 done", done, 1);
    check("npts0 busy", busy, 0);
    @(negedge clk);
    check("npts0 done drop", done, 0);
    check("npts0 busy after", busy, 0);

    // Backpressure burst of four under identity.
    @(negedge clk);
    cfg_we = 1'b1; cfg_coeff = pack_c(1, 0, 0, 0, 1, 0); cfg_shift = '0;
    start = 1'b1; npts = 4'd4;
    @(negedge clk);
    cfg_we = 1'b0; start = 1'b0;
    stream(4, 5, "bp");

    // cfg_we and start during RUN must be ignored.
    @(negedge clk);
    start = 1'b1; npts = 4'd2;
    @(negedge clk);
    cfg_we = 1'b1; cfg_coeff = pack_c(1, 0, 100, 0, 1, 100); start = 1'b1; npts = 4'd1;
    check("run_ign busy", busy, 1);
    @(negedge clk);
    cfg_we = 1'b0; start = 1'b0;
    stream(2, 0, "run_ign");

    // npts above MAX_PTS clamps to MAX_PTS.
    @(negedge clk);
    start = 1'b1; npts = 4'd15;
    @(negedge clk);
    start = 1'b0;
    stream(MAX_PTS, 0, "clamp");

    // Reset mid-burst with a stalled result sitting on the output.
    @(negedge clk);
    cfg_we = 1'b1; cfg_coeff = pack_c(2, 0, 9, 0, 2, 9); cfg_shift = '0;
    start = 1'b1; npts = 4'd3;
    @(negedge clk);
    cfg_we = 1'b0; start = 1'b0;
    io.res_ready = 1'b0;
    io.pt_valid = 1'b1; io.pt_x = 16'sd5; io.pt_y = 16'sd5;
    @(negedge clk);
    io.pt_valid = 1'b0;
    @(negedge clk);
    check("rst_mid pre res_valid", io.res_valid, 1);
    check("rst_mid pre res_x", io.res_x, 19);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid res_valid", io.res_valid, 0);
    check("rst_mid res_x", io.res_x, 0);
    check("rst_mid res_y", io.res_y, 0);
    check("rst_mid res_last", io.res_last, 0);
    check("rst_mid busy", busy, 0);
    check("rst_mid pt_ready", io.pt_ready, 0);
    check("rst_mid done", done, 0);
`ifdef AFFINE_SAT_EN
    check("rst_mid sat_flag", io.sat_flag, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    io.res_ready = 1'b1;
    done_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("rst_mid no done", done_seen, 0);
    idv = '{"post_rst", 1, 0, 0, 0, 1, 0, 0, 7, 9, 7, 9, 1'b0};
    run_vec(idv, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
